// File: rtl/morra_giocatori.sv
// morra_giocatori: self-playing two-player move source for the morra cinese referee.
// Generates pseudo-random rock/paper/scissors moves from two 8-bit LFSRs.
// It reads each manche result back and tracks the move each player is
// blocked from repeating. It stops on a referee game result or after
// MAX_MANCHE valid manche.
// Optional feature: define MORRA_LEGAL_ONLY_EN to substitute blocked moves
// so that only legal moves are presented to the referee.
module morra_giocatori #(
    parameter logic [7:0] SEED1      = 8'hA5,
    parameter logic [7:0] SEED2      = 8'h3C,
    parameter logic [4:0] MAX_MANCHE = 5'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cfg_extra,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic [1:0] primo,
    output logic [1:0] secondo,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       timeout,
    output logic [4:0] played,
    output logic [4:0] rejected
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
    localparam logic [7:0] SEED2_EFF = (SEED2 == 8'h00) ? 8'h01 : SEED2;

    localparam logic [4:0] CNT_MAX = 5'd31;

    state_e     state_q, state_d;
    logic [7:0] lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
    logic [1:0] mv1_q, mv1_d, mv2_q, mv2_d;
    logic [1:0] blk1_q, blk1_d, blk2_q, blk2_d;
    logic [4:0] played_q, played_d, rejected_q, rejected_d;
    logic [1:0] winner_q, winner_d;
    logic       timeout_q, timeout_d;
    logic [1:0] cand1, cand2;

    // x^8+x^6+x^5+x^4+1, shifting left with the feedback entering bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Low two LFSR bits give the move; the unused code 00 folds onto sasso.
    function automatic logic [1:0] raw_move(input logic [7:0] v);
        return (v[1:0] == 2'b00) ? 2'b01 : v[1:0];
    endfunction

`ifdef MORRA_LEGAL_ONLY_EN
    // A blocked move is rotated to the next one in the cycle 01->10->11->01.
    function automatic logic [1:0] legal_move(input logic [1:0] m, input logic [1:0] blk);
        if (m != blk) return m;
        return (m == 2'b11) ? 2'b01 : m + 2'b01;
    endfunction

    assign cand1 = legal_move(raw_move(lfsr1_q), blk1_q);
    assign cand2 = legal_move(raw_move(lfsr2_q), blk2_q);
`else
    assign cand1 = raw_move(lfsr1_q);
    assign cand2 = raw_move(lfsr2_q);
`endif

    // Next-state and datapath update for the PLAY/WAIT/CHECK manche loop.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        lfsr1_d    = lfsr1_q;
        lfsr2_d    = lfsr2_q;
        mv1_d      = mv1_q;
        mv2_d      = mv2_q;
        blk1_d     = blk1_q;
        blk2_d     = blk2_q;
        played_d   = played_q;
        rejected_d = rejected_q;
        winner_d   = winner_q;
        timeout_d  = timeout_q;
        busy       = 1'b0;
        game_over  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PLAY;
                    blk1_d     = 2'b00;
                    blk2_d     = 2'b00;
                    played_d   = 5'd0;
                    rejected_d = 5'd0;
                    winner_d   = 2'b00;
                    timeout_d  = 1'b0;
                    // Blocked moves are being cleared, so no substitution applies.
                    mv1_d      = raw_move(lfsr1_q);
                    mv2_d      = raw_move(lfsr2_q);
                end
            end
            S_PLAY: begin
                busy    = 1'b1;
                lfsr1_d = lfsr_step(lfsr1_q);
                lfsr2_d = lfsr_step(lfsr2_q);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                state_d = S_CHECK;
                if (manche == 2'b00) begin
                    if (rejected_q != CNT_MAX) rejected_d = rejected_q + 5'd1;
                end else begin
                    if (played_q != CNT_MAX) played_d = played_q + 5'd1;
                    case (manche)
                        2'b01:   begin blk1_d = mv1_q; blk2_d = 2'b00; end
                        2'b10:   begin blk2_d = mv2_q; blk1_d = 2'b00; end
                        default: begin blk1_d = 2'b00; blk2_d = 2'b00; end
                    endcase
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                // A referee result takes priority over the manche limit.
                if (partita != 2'b00) begin
                    state_d  = S_DONE;
                    winner_d = partita;
                end else if (played_q == MAX_MANCHE) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_PLAY;
                    mv1_d   = cand1;
                    mv2_d   = cand2;
                end
            end
            S_DONE: begin
                game_over = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset reloads seeds and clears the game.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr1_q    <= SEED1_EFF;
            lfsr2_q    <= SEED2_EFF;
            mv1_q      <= 2'b00;
            mv2_q      <= 2'b00;
            blk1_q     <= 2'b00;
            blk2_q     <= 2'b00;
            played_q   <= 5'd0;
            rejected_q <= 5'd0;
            winner_q   <= 2'b00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr1_q    <= lfsr1_d;
            lfsr2_q    <= lfsr2_d;
            mv1_q      <= mv1_d;
            mv2_q      <= mv2_d;
            blk1_q     <= blk1_d;
            blk2_q     <= blk2_d;
            played_q   <= played_d;
            rejected_q <= rejected_d;
            winner_q   <= winner_d;
            timeout_q  <= timeout_d;
        end
    end

    // During reset the moves carry the referee's extra-manche configuration.
    assign primo    = reset ? cfg_extra[3:2] : ((state_q == S_PLAY) ? mv1_q : 2'b00);
    assign secondo  = reset ? cfg_extra[1:0] : ((state_q == S_PLAY) ? mv2_q : 2'b00);
    assign winner   = winner_q;
    assign timeout  = timeout_q;
    assign played   = played_q;
    assign rejected = rejected_q;

endmodule

// File: tb/tb_morra_giocatori.sv
// Testbench for morra_giocatori: acts as a randomised referee stub and compares
// every manche against a transaction-level model of the game rules.
module tb_morra_giocatori;

    localparam logic [4:0] T_MAX = 5'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] cfg_extra;
    logic [1:0] manche;
    logic [1:0] partita;
    logic [1:0] primo;
    logic [1:0] secondo;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic       timeout;
    logic [4:0] played;
    logic [4:0] rejected;

    int n_checks = 0;
    int n_pass   = 0;

    morra_giocatori #(
        .SEED1      (8'hA5),
        .SEED2      (8'h3C),
        .MAX_MANCHE (T_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_extra (cfg_extra),
        .manche    (manche),
        .partita   (partita),
        .primo     (primo),
        .secondo   (secondo),
        .busy      (busy),
        .game_over (game_over),
        .winner    (winner),
        .timeout   (timeout),
        .played    (played),
        .rejected  (rejected)
    );

    always #5 clk = ~clk;

    // Reference model state, kept at manche granularity.
    logic [7:0] m_l1, m_l2;
    logic [1:0] m_b1, m_b2;
    int         m_played, m_rej;
    logic [1:0] m_win;
    bit         m_to, m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic logic [1:0] model_move(input logic [7:0] l, input logic [1:0] blk);
        int m;
        m = l % 4;
        if (m == 0) m = 1;
`ifdef MORRA_LEGAL_ONLY_EN
        if (m == int'(blk)) m = (m % 3) + 1;
`else
        if (blk == 2'b11 && m == 0) m = 1;  // blocked move has no effect on raw moves
`endif
        return m[1:0];
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 31) ? 31 : v + 1;
    endfunction

    // Reset asserted now (any phase away from the posedge), released one negedge later.
    task automatic do_reset(input logic [3:0] cfg);
        reset = 1'b1; cfg_extra = cfg; start = 1'b0; manche = 2'b00; partita = 2'b00;
        #1;
        check("rst_primo",   primo,   cfg[3:2]);
        check("rst_secondo", secondo, cfg[1:0]);
        check("rst_busy",    busy,    0);
        check("rst_over",    game_over, 0);
        check("rst_played",  played,  0);
        check("rst_rej",     rejected, 0);
        check("rst_winner",  winner,  0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        reset = 1'b0;
        m_l1 = 8'hA5; m_l2 = 8'h3C; m_b1 = 2'b00; m_b2 = 2'b00;
        m_played = 0; m_rej = 0; m_win = 2'b00; m_to = 1'b0; m_done = 1'b0;
        #1;
        check("post_rst_primo",   primo,   0);
        check("post_rst_secondo", secondo, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_primo", primo, 0);
    endtask

    // Pulse (or hold) start from IDLE; returns at the negedge inside PLAY.
    task automatic begin_game(input bit hold_start);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        m_b1 = 2'b00; m_b2 = 2'b00; m_played = 0; m_rej = 0;
        m_win = 2'b00; m_to = 1'b0; m_done = 1'b0;
    endtask

    // Plays one manche; entered at the negedge inside PLAY.
    task automatic do_manche(input logic [1:0] mres, input logic [1:0] pres, input bit abort);
        logic [1:0] e1, e2;
        e1 = model_move(m_l1, m_b1);
        e2 = model_move(m_l2, m_b2);
        #1;
        check("play_primo",   primo,   e1);
        check("play_secondo", secondo, e2);
        check("play_busy",    busy,    1);
        m_l1 = lfsr_next(m_l1);
        m_l2 = lfsr_next(m_l2);
        @(negedge clk);
        manche = mres;
        #1;
        check("wait_primo", primo, 0);
        if (abort) begin
            do_reset($urandom_range(0, 15));
            return;
        end
        @(negedge clk);
        manche = 2'b00;
        partita = pres;
        case (mres)
            2'b00: m_rej = sat_inc(m_rej);
            2'b01: begin m_b1 = e1; m_b2 = 2'b00; m_played = sat_inc(m_played); end
            2'b10: begin m_b2 = e2; m_b1 = 2'b00; m_played = sat_inc(m_played); end
            default: begin m_b1 = 2'b00; m_b2 = 2'b00; m_played = sat_inc(m_played); end
        endcase
        #1;
        check("played",   played,   m_played);
        check("rejected", rejected, m_rej);
        check("check_secondo", secondo, 0);
        @(negedge clk);
        partita = 2'b00;
        if (pres != 2'b00) begin
            m_done = 1'b1; m_win = pres;
        end else if (m_played == int'(T_MAX)) begin
            m_done = 1'b1; m_to = 1'b1;
        end
        #1;
        check("game_over", game_over, m_done);
        check("busy",      busy,      !m_done);
        check("winner",    winner,    m_win);
        check("timeout",   timeout,   m_to);
    endtask

    // DONE must hold outputs and ignore start.
    task automatic check_done_hold();
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("done_over",   game_over, 1);
            check("done_primo",  primo,     0);
            check("done_winner", winner,    m_win);
            check("done_played", played,    m_played);
        end
        start = 1'b0;
    endtask

    task automatic run_random_game();
        int n;
        logic [1:0] mr, pr;
        begin_game($urandom_range(0, 1));
        n = 0;
        while (!m_done && n < 200) begin
            mr = 2'($urandom_range(0, 3));
            pr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_manche(mr, pr, 1'b0);
            n++;
        end
        check("rand_game_over", game_over, 1);
        check_done_hold();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cfg_extra = 4'b0000; manche = 2'b00; partita = 2'b00;
        @(negedge clk);

        // Configuration split during reset.
        do_reset(4'b0110);

        // Partita result ends the game; winner captured.
        begin_game(1'b0);
        do_manche(2'b01, 2'b00, 1'b0);
        do_manche(2'b00, 2'b00, 1'b0);
        do_manche(2'b10, 2'b10, 1'b0);
        check("dir_winner", winner, 2'b10);
        check_done_hold();

        // Rejection counter saturates at 31; played unaffected.
        do_reset(4'b1001);
        begin_game(1'b0);
        for (int i = 0; i < 34; i++) do_manche(2'b00, 2'b00, 1'b0);
        check("sat_rejected", rejected, 31);
        do_manche(2'b01, 2'b01, 1'b0);

        // Timeout after T_MAX ties.
        do_reset(4'b1111);
        begin_game(1'b1);
        for (int i = 0; i < 3; i++) do_manche(2'b11, 2'b00, 1'b0);
        check("to_timeout", timeout, 1);
        check("to_winner",  winner,  0);
        check("to_played",  played,  3);
        check_done_hold();

        // Result and limit together: result wins.
        do_reset(4'b0011);
        begin_game(1'b0);
        do_manche(2'b01, 2'b00, 1'b0);
        do_manche(2'b10, 2'b00, 1'b0);
        do_manche(2'b11, 2'b01, 1'b0);
        check("prio_timeout", timeout, 0);
        check("prio_winner",  winner,  2'b01);

        // Reset during WAIT discards the manche.
        do_reset(4'b0101);
        begin_game(1'b0);
        do_manche(2'b01, 2'b00, 1'b0);
        do_manche(2'b10, 2'b00, 1'b1);

        // Randomised games.
        for (int g = 0; g < 30; g++) begin
            do_reset(4'($urandom_range(0, 15)));
            run_random_game();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/morra_giocatori.md
# morra_giocatori

Two-player move generator that drives the morra cinese referee from the opposite side of its move interface. It produces pseudo-random rock/paper/scissors moves for both players and presents the manche-count configuration during reset. It reads back each manche result, tracks each player's blocked move, and stops when the referee declares a game result or a safety limit is reached. It is used as the self-playing stimulus source in system simulation and on the demo board.

## Interface
Parameters:
- `SEED1`, 8'hA5: LFSR seed for player 1. A value of 0 is replaced by 8'h01.
- `SEED2`, 8'h3C: LFSR seed for player 2. A value of 0 is replaced by 8'h01.
- `MAX_MANCHE`, 5'd20: limit on valid manche before a forced timeout.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a game; sampled only in IDLE.
- `cfg_extra`  in  4  extra-manche configuration; driven onto the moves while `reset` is high.
- `manche`  in  2  referee manche result: 00 none/invalid, 01 player 1 wins, 10 player 2 wins, 11 tie.
- `partita`  in  2  referee game result: 00 running, 01 player 1, 10 player 2, 11 draw.
- `primo`  out  2  player 1 move: 00 none, 01 sasso, 10 carta, 11 forbice.
- `secondo`  out  2  player 2 move, same encoding as `primo`.
- `busy`  out  1  high in PLAY, WAIT and CHECK.
- `game_over`  out  1  high in DONE.
- `winner`  out  2  captured `partita`; 00 on timeout.
- `timeout`  out  1  set when `MAX_MANCHE` is reached without a result.
- `played`  out  5  count of valid manche (`manche` != 00).
- `rejected`  out  5  count of manche the referee returned as 00.

## Operation
- States: IDLE, PLAY, WAIT, CHECK, DONE.
- IDLE: moves 00. `start` -> PLAY. `blk1`, `blk2`, `played`, `rejected`, `timeout`, `winner` all cleared on entry via `start`.
- PLAY (one cycle):
  - Register moves derived from the LFSRs and drive them.
  - Both LFSRs advance one step.
  - Next state: WAIT.
- Move derivation per player:
  - `m` = LFSR[1:0]; 00 maps to 01.
  - Legal-move substitution (see Configuration): if `m` equals the player's blocked move, replace it with the next move in the cycle 01->10->11->01.
- WAIT (one cycle):
  - Moves 00.
  - Sample `manche`:
    - 01: `blk1` <= last `primo`, `blk2` <= 00, `played`++.
    - 10: `blk2` <= last `secondo`, `blk1` <= 00, `played`++.
    - 11: both blocked moves cleared, `played`++.
    - 00: `rejected`++, blocked moves unchanged.
  - Next state: CHECK.
- CHECK (one cycle), moves 00, in priority order:
  - `partita` != 00 -> DONE, `winner` <= `partita`.
  - Else `played` == `MAX_MANCHE` -> DONE, `timeout` <= 1.
  - Else -> PLAY.
- DONE: moves 00, outputs held. Exit only through `reset`; `start` is ignored.
- LFSRs are 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left with the feedback bit into bit 0. They are loaded with the seeds on reset.
- Counters `played` and `rejected` saturate at 31.

## Timing
- Reset values: state IDLE, all counters 0, `busy`=0, `game_over`=0, `winner`=00, `timeout`=0, `blk1`=`blk2`=00, LFSRs at their seeds.
- While `reset` is high, `primo` = `cfg_extra[3:2]` and `secondo` = `cfg_extra[1:0]`, combinationally. This lets the referee load its manche target.
- After `reset` deasserts, moves come from registers and read 00 until PLAY.
- Each manche takes exactly 3 cycles (PLAY, WAIT, CHECK). Moves are non-zero only during PLAY.
- `manche` is registered by the referee, so it is sampled the cycle after PLAY.
- `partita` is sampled one cycle after that, in CHECK.
- `start` held high: only the first cycle in IDLE counts.
- `reset` mid-game: immediate return to IDLE with all reset values; any partial manche is discarded.
- `partita` result and the `MAX_MANCHE` limit in the same CHECK cycle: the result wins and `timeout` stays 0.

## Configuration
- `MORRA_LEGAL_ONLY_EN` defined: blocked-move substitution is active, so the referee should never reject a move. `rejected` still counts any 00 result, so a non-zero value flags a referee bug.
- `MORRA_LEGAL_ONLY_EN` undefined: raw mapped LFSR moves are driven, so repeats of blocked moves reach the referee. This exercises the referee's rejection path; `rejected` counts the rejections and the manche is replayed with fresh LFSR values.

## Test plan
- Reset with `cfg_extra`=4'b0110 -> `primo`=01 and `secondo`=10 during reset; 00 and IDLE after deassert.
- `start`, then stub `manche`=01 after a PLAY with `primo`=11 -> `blk1`=11; the next PLAY (legal-only) has `primo`≠11.
- Stub `manche`=00 in WAIT -> `rejected`=1, `played` unchanged, next state PLAY.
- Stub `partita`=10 in CHECK -> DONE next cycle, `winner`=10, `game_over`=1, moves 00 thereafter.
- `MAX_MANCHE`=3, stub `manche`=11 three times with `partita`=00 -> DONE, `timeout`=1, `winner`=00, `played`=3.
- Assert `reset` during WAIT -> IDLE at once, counters 0, moves = `cfg_extra` split while reset is high; end-to-end run with the real referee ends with `partita`≠00 and `rejected`=0 (legal-only).
